// File: rtl/mem_cfg_pkg.sv
// Shared types and lane helpers for the configurable simple-dual-port block RAM.
// Helpers operate on 32-bit containers; callers truncate to their physical width.
package mem_cfg_pkg;

    typedef enum logic {CLEAR, READY} state_t;

    function automatic int unsigned clamp_mode(input int unsigned mode, input int unsigned max_m);
        return (mode > max_m) ? max_m : mode;
    endfunction

    function automatic logic [31:0] width_mask(input int unsigned lw);
        return (lw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << lw) - 32'd1);
    endfunction

    function automatic logic [31:0] lane_mask(input int unsigned dw, input int unsigned mode,
                                              input int unsigned lane);
        int unsigned lw;
        lw = dw >> mode;
        return width_mask(lw) << (lane * lw);
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] word, input int unsigned dw,
                                                 input int unsigned mode, input int unsigned lane);
        int unsigned lw;
        lw = dw >> mode;
        return (word >> (lane * lw)) & width_mask(lw);
    endfunction

endpackage

// File: rtl/mem_cfg_lane_map.sv
// Splits a logical address into physical word and lane for a given aspect ratio,
// and produces the lane bit mask plus the data field replicated into every lane.
module mem_cfg_lane_map
    import mem_cfg_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int MAX_M  = 3,
    parameter int LANE_W = 3
) (
    input  logic [ADDR_W+MAX_M-1:0] addr,
    input  logic [2:0]              mode,
    input  logic [DATA_W-1:0]       data,
    output logic [ADDR_W-1:0]       word,
    output logic [LANE_W-1:0]       lane,
    output logic [DATA_W-1:0]       mask,
    output logic [DATA_W-1:0]       rep
);

    localparam int unsigned NLANES = 1 << MAX_M;
    localparam logic [ADDR_W+MAX_M-1:0] ONES = '1;

    logic [31:0] field;
    logic [31:0] rep_acc;
    int unsigned lw;

    always_comb begin
        word    = ADDR_W'(addr >> mode);
        lane    = LANE_W'(addr & ~(ONES << mode));
        mask    = DATA_W'(lane_mask(DATA_W, 32'(mode), 32'(lane)));
        lw      = DATA_W >> mode;
        field   = 32'(data) & width_mask(lw);
        rep_acc = '0;
        for (int unsigned k = 0; k < NLANES; k++) begin
            if (k < (32'd1 << mode))
                rep_acc = rep_acc | (field << (k * lw));
        end
        rep = DATA_W'(rep_acc);
    end

endmodule

// File: rtl/mem_cfg_sdp_bram.sv
// Simple-dual-port block RAM with runtime aspect ratio, read-during-write policy,
// optional output register and a zero-fill clear engine run after reset or on clr.
module mem_cfg_sdp_bram
    import mem_cfg_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8,
    parameter int MODE_W  = 2,
    parameter int OUT_REG = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [MODE_W-1:0]                cfg_mode,
    input  logic                             cfg_wr_first,
    input  logic                             clr,
    input  logic                             wen,
    input  logic [ADDR_W+$clog2(DATA_W)-1:0] waddr,
    input  logic [DATA_W-1:0]                wdata,
    input  logic                             ren,
    input  logic [ADDR_W+$clog2(DATA_W)-1:0] raddr,
    output logic [DATA_W-1:0]                rdata,
    output logic                             rvalid,
    output logic                             busy
);

    localparam int MAX_M  = $clog2(DATA_W);
    localparam int LANE_W = (MAX_M > 0) ? MAX_M : 1;

    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic [2:0]          mode_c;

    logic [ADDR_W-1:0]   w_word, r_word;
    logic [LANE_W-1:0]   w_lane, r_lane;
    logic [DATA_W-1:0]   w_mask, r_mask, w_rep, r_rep;

    logic [DATA_W-1:0]   mem [2**ADDR_W];
    logic [DATA_W-1:0]   old_word, rd_word, rd_lane;
    logic                hit;
    logic [DATA_W-1:0]   rdata_q;
    logic                rvalid_q;

    assign mode_c = 3'(clamp_mode(32'(cfg_mode), MAX_M));
    assign busy   = (state == CLEAR);

    mem_cfg_lane_map #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_M(MAX_M), .LANE_W(LANE_W)) u_wmap (
        .addr (waddr),
        .mode (mode_c),
        .data (wdata),
        .word (w_word),
        .lane (w_lane),
        .mask (w_mask),
        .rep  (w_rep)
    );

    mem_cfg_lane_map #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_M(MAX_M), .LANE_W(LANE_W)) u_rmap (
        .addr (raddr),
        .mode (mode_c),
        .data (wdata),
        .word (r_word),
        .lane (r_lane),
        .mask (r_mask),
        .rep  (r_rep)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr)
                        cnt <= '0;
                    else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == '1)
                            state <= READY;
                    end
                end
                READY: begin
                    if (clr) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR)
            mem[cnt] <= '0;
        else if (wen)
            mem[w_word] <= (mem[w_word] & ~w_mask) | (w_rep & w_mask);
    end

    // Same mode on both ports, so equal word and lane means the write lands exactly on
    // the read lane; write-first substitutes the incoming lane data into the read word.
    always_comb begin
        old_word = mem[r_word];
        hit      = wen && (w_word == r_word) && (w_lane == r_lane);
        rd_word  = (hit && cfg_wr_first) ? ((old_word & ~r_mask) | (r_rep & r_mask)) : old_word;
        rd_lane  = DATA_W'(lane_extract(32'(rd_word), DATA_W, 32'(mode_c), 32'(r_lane)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= ren && (state == READY);
            if (ren && (state == READY))
                rdata_q <= rd_lane;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] rdata_p;
            logic              rvalid_p;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rdata_p  <= '0;
                    rvalid_p <= 1'b0;
                end else begin
                    rvalid_p <= rvalid_q;
                    if (rvalid_q)
                        rdata_p <= rdata_q;
                end
            end

            assign rdata  = rdata_p;
            assign rvalid = rvalid_p;
        end else begin : g_no_reg
            assign rdata  = rdata_q;
            assign rvalid = rvalid_q;
        end
    endgenerate

endmodule

// File: tb/tb_mem_cfg_sdp_bram.sv
// Bench for mem_cfg_sdp_bram: two instances (OUT_REG 0 and 1) share stimulus and are
// compared each cycle against an arithmetic model of the logical memory.
module tb_mem_cfg_sdp_bram;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  cfg_mode = '0;
    logic        cfg_wr_first = 1'b0;
    logic        clr = 1'b0;
    logic        wen = 1'b0;
    logic        ren = 1'b0;
    logic [12:0] waddr = '0;
    logic [12:0] raddr = '0;
    logic [7:0]  wdata = '0;
    logic [7:0]  rdata0, rdata1;
    logic        rvalid0, rvalid1, busy0, busy1;

    always #5 clk = ~clk;

    mem_cfg_sdp_bram #(.ADDR_W(10), .DATA_W(8), .MODE_W(2), .OUT_REG(0)) dut0 (
        .clk(clk), .reset(reset), .cfg_mode(cfg_mode), .cfg_wr_first(cfg_wr_first),
        .clr(clr), .wen(wen), .waddr(waddr), .wdata(wdata), .ren(ren), .raddr(raddr),
        .rdata(rdata0), .rvalid(rvalid0), .busy(busy0)
    );

    mem_cfg_sdp_bram #(.ADDR_W(10), .DATA_W(8), .MODE_W(2), .OUT_REG(1)) dut1 (
        .clk(clk), .reset(reset), .cfg_mode(cfg_mode), .cfg_wr_first(cfg_wr_first),
        .clr(clr), .wen(wen), .waddr(waddr), .wdata(wdata), .ren(ren), .raddr(raddr),
        .rdata(rdata1), .rvalid(rvalid1), .busy(busy1)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned ref_mem [1024];
    int          busy_left = 0;
    int          e1d = 0, e1v = 0, e2d = 0, e2v = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned cur_mode();
        return (int'(cfg_mode) > 3) ? 3 : int'(cfg_mode);
    endfunction

    // Logical lane value = digit ln (base 2**lw) of the physical word.
    function automatic int unsigned ref_read(input int unsigned addr, input int unsigned m);
        int unsigned lw, w, ln;
        lw = 8 >> m;
        w  = (addr >> m) % 1024;
        ln = addr % (1 << m);
        return (ref_mem[w] / (1 << (ln * lw))) % (1 << lw);
    endfunction

    function automatic void ref_write(input int unsigned addr, input int unsigned m,
                                      input int unsigned data);
        int unsigned lw, w, ln, sh, old_f, new_f;
        lw    = 8 >> m;
        w     = (addr >> m) % 1024;
        ln    = addr % (1 << m);
        sh    = 1 << (ln * lw);
        old_f = (ref_mem[w] / sh) % (1 << lw);
        new_f = data % (1 << lw);
        ref_mem[w] = ref_mem[w] - old_f * sh + new_f * sh;
    endfunction

    function automatic void ref_zero();
        for (int i = 0; i < 1024; i++) ref_mem[i] = 0;
    endfunction

    task automatic cycle();
        int  v;
        bit  acc_r, acc_w;
        v     = 0;
        acc_r = (busy_left == 0) && ren;
        acc_w = (busy_left == 0) && wen;
        if (acc_r && acc_w && cfg_wr_first) begin
            ref_write(waddr, cur_mode(), wdata);
            v = ref_read(raddr, cur_mode());
        end else begin
            if (acc_r) v = ref_read(raddr, cur_mode());
            if (acc_w) ref_write(waddr, cur_mode(), wdata);
        end
        if (e1v != 0) e2d = e1d;
        e2v = e1v;
        e1v = acc_r ? 1 : 0;
        if (acc_r) e1d = v;
        if (clr) begin
            busy_left = 1024;
            ref_zero();
        end else if (busy_left > 0) begin
            busy_left--;
        end
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("busy0", busy0, busy_left > 0);
        check("busy1", busy1, busy_left > 0);
        check("rvalid0", rvalid0, e1v);
        check("rdata0", rdata0, e1d);
        check("rvalid1", rvalid1, e2v);
        check("rdata1", rdata1, e2d);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        busy_left = 1024;
        e1d = 0; e1v = 0; e2d = 0; e2v = 0;
        ref_zero();
        check("rst_rdata0", rdata0, 0);
        check("rst_rvalid0", rvalid0, 0);
        check("rst_busy0", busy0, 1);
        check("rst_rdata1", rdata1, 0);
        check("rst_rvalid1", rvalid1, 0);
        check("rst_busy1", busy1, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_clear(input string tag, input int exp_len);
        int n;
        n = 0;
        while (busy0 && n < 3000) begin
            cycle();
            n++;
        end
        check(tag, n, exp_len);
    endtask

    task automatic wr(input int unsigned a, input int unsigned d);
        wen = 1'b1; waddr = 13'(a); wdata = 8'(d);
        cycle();
        wen = 1'b0;
    endtask

    task automatic rd_expect(input int unsigned a, input int unsigned exp, input string tag);
        ren = 1'b1; raddr = 13'(a);
        cycle();
        check({tag, "_data0"}, rdata0, exp);
        check({tag, "_valid0"}, rvalid0, 1);
        ren = 1'b0;
        cycle();
        check({tag, "_data1"}, rdata1, exp);
        check({tag, "_valid1"}, rvalid1, 1);
        check({tag, "_pulse0"}, rvalid0, 0);
    endtask

    task automatic collide(input int unsigned a, input int unsigned d, input bit wf,
                           input int unsigned exp, input string tag);
        cfg_wr_first = wf;
        wen = 1'b1; ren = 1'b1; waddr = 13'(a); raddr = 13'(a); wdata = 8'(d);
        cycle();
        check({tag, "_data0"}, rdata0, exp);
        wen = 1'b0; ren = 1'b0;
        cycle();
        check({tag, "_data1"}, rdata1, exp);
    endtask

    task automatic random_phase(input int ncyc);
        int unsigned m, wd, ln, a;
        for (int i = 0; i < ncyc; i++) begin
            m  = $urandom_range(0, 3);
            cfg_mode = 2'(m);
            cfg_wr_first = 1'($urandom_range(0, 1));
            wd = $urandom_range(0, 7);
            ln = $urandom_range(0, (1 << m) - 1);
            a  = ($urandom << (10 + m)) | (wd << m) | ln;
            waddr = 13'(a);
            if ($urandom_range(0, 1) == 0) begin
                wd = $urandom_range(0, 7);
                ln = $urandom_range(0, (1 << m) - 1);
            end
            a  = ($urandom << (10 + m)) | (wd << m) | ln;
            raddr = 13'(a);
            wdata = 8'($urandom);
            wen = 1'($urandom_range(0, 1));
            ren = 1'($urandom_range(0, 1));
            cycle();
        end
        wen = 1'b0; ren = 1'b0; cfg_mode = 2'd0; cfg_wr_first = 1'b0;
    endtask

    initial begin
        int n;
        #2;
        do_reset();
        wait_clear("init_clear_len", 1024);

        rd_expect($urandom_range(0, 8191), 0, "rd_zero");
        wr(5, 8'hA5);
        rd_expect(5, 8'hA5, "rd_a5");

        cfg_mode = 2'd3;
        wr(41, 1);
        cfg_mode = 2'd0;
        rd_expect(5, 8'hA7, "rd_a7");
        rd_expect(5 + 5 * 1024, 8'hA7, "rd_hi_ignored");
        cfg_mode = 2'd1;
        rd_expect(11, 8'h0A, "rd_nibble");
        cfg_mode = 2'd0;

        wr(7, 8'h11);
        collide(7, 8'h22, 1'b1, 8'h22, "wr_first");
        wr(7, 8'h11);
        collide(7, 8'h22, 1'b0, 8'h11, "rd_first");
        rd_expect(7, 8'h22, "after_rd_first");

        random_phase(600);

        wr(5, 8'h5C);
        clr = 1'b1;
        cycle();
        n = 0;
        while (busy0 && n < 3000) begin
            if (n == 200) clr = 1'b1;
            wen = 1'($urandom_range(0, 1));
            ren = 1'($urandom_range(0, 1));
            waddr = 13'($urandom_range(0, 15));
            raddr = 13'($urandom_range(0, 15));
            wdata = 8'($urandom);
            cycle();
            n++;
        end
        wen = 1'b0; ren = 1'b0;
        check("clr_restart_len", n, 1225);
        rd_expect(5, 0, "rd_after_clr");

        clr = 1'b1;
        cycle();
        repeat (300) cycle();
        do_reset();
        wait_clear("reset_mid_clear_len", 1024);

        wr(9, 8'h5A);
        ren = 1'b1; raddr = 13'd9;
        cycle();
        ren = 1'b0;
        do_reset();
        wait_clear("reset_mid_read_len", 1024);
        rd_expect(9, 0, "rd_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
